// File: rtl/button_conditioner_if.sv
// Pushbutton front-end bundle: raw board buttons in, clean press pulses and debounced levels out.
interface button_conditioner_if;
  logic       raw_up;
  logic       raw_down;
  logic       raw_pause;
  logic       speed_u;
  logic       speed_d;
  logic       btn_p;
  logic [2:0] btn_held;

  modport master (
    output raw_up, raw_down, raw_pause,
    input  speed_u, speed_d, btn_p, btn_held
  );

  modport slave (
    input  raw_up, raw_down, raw_pause,
    output speed_u, speed_d, btn_p, btn_held
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronise, debounce and arbitrate three pushbuttons into one-cycle press pulses.
// Optional HOLD_REPEAT_EN macro adds auto-repeat on held up/down buttons.
module button_conditioner #(
  parameter int DEBOUNCE_CYC = 200000,
  parameter int REPEAT_DLY   = 5000000,
  parameter int REPEAT_PER   = 2500000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  btn
);

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} db_state_e;

  if (DEBOUNCE_CYC < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_err
    $error("button_conditioner: DEBOUNCE_CYC must be >= 2, repeat timings >= 1");
  end

  logic [2:0] raw;
  logic [2:0] sync_p0, sync_p1;
  logic [2:0] accept;
  logic [2:0] rep_fire;
  logic [2:0] held_vec;
  logic [2:0] pend_q, pend_d;
  logic [2:0] grant;
  logic [2:0] pulse_p2;

  assign raw = {btn.raw_pause, btn.raw_down, btn.raw_up};

  // stage p0/p1: two-flop synchroniser per button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_btn
    db_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            held_q, held_d;
    logic            acc;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        held_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        held_q  <= held_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      held_d  = held_q;
      acc     = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sync_p1[i]) begin
            state_d = PRESS_CHK;
            cnt_d   = '0;
          end
        end
        PRESS_CHK: begin
          if (!sync_p1[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            held_d  = 1'b1;
            acc     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!sync_p1[i]) begin
            state_d = REL_CHK;
            cnt_d   = '0;
          end
        end
        REL_CHK: begin
          if (sync_p1[i]) begin
            state_d = HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            held_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign accept[i]   = acc;
    assign held_vec[i] = held_q;

`ifdef HOLD_REPEAT_EN
    if (i < 2) begin : g_rep
      localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
      localparam int RW   = $clog2(RMAX + 1);
      logic [RW-1:0] rcnt_q;
      logic          rstarted_q;
      logic          rterm;

      // first repeat after REPEAT_DLY cycles in HELD, then every REPEAT_PER
      assign rterm = (state_q == HELD) &&
                     (rcnt_q == (rstarted_q ? RW'(REPEAT_PER - 1) : RW'(REPEAT_DLY - 1)));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rcnt_q     <= '0;
          rstarted_q <= 1'b0;
        end else if (state_q != HELD) begin
          rcnt_q     <= '0;
          rstarted_q <= 1'b0;
        end else if (rterm) begin
          rcnt_q     <= '0;
          rstarted_q <= 1'b1;
        end else begin
          rcnt_q <= rcnt_q + 1'b1;
        end
      end

      assign rep_fire[i] = rterm;
    end else begin : g_norep
      assign rep_fire[i] = 1'b0;
    end
`else
    assign rep_fire[i] = 1'b0;
`endif
  end

  // stage p2: fixed-priority arbitration, up > down > pause
  always_comb begin
    grant = 3'b000;
    if (pend_q[0])      grant = 3'b001;
    else if (pend_q[1]) grant = 3'b010;
    else if (pend_q[2]) grant = 3'b100;
    pend_d = (pend_q & ~grant) | accept | rep_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      pulse_p2 <= '0;
    end else begin
      pend_q   <= pend_d;
      pulse_p2 <= grant;
    end
  end

  assign btn.speed_u  = pulse_p2[0];
  assign btn.speed_d  = pulse_p2[1];
  assign btn.btn_p    = pulse_p2[2];
  assign btn.btn_held = held_vec;

endmodule
